m_7seg_scan_ctrl: RTL

Time-multiplexed scan controller for a multi-digit 7-segment display. It shares one combinational 4-bit-to-7-segment decoder (abcdefg order, active-high segments, codes 10-15 decode to blank) across DIGITS digit positions. It sequences digit selection with a blanking gap between digits against ghosting, blanks leading zeros, and double-buffers the displayed value so that updates commit only at frame boundaries. It sits between the datapath that produces a display value and the board's segment and digit-enable pins.

---
 rtl/m_7seg_scan_ctrl_if.sv | 25 ++
 rtl/m_7seg_scan_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/m_7seg_scan_ctrl_if.sv
// Display-value load bus and segment/digit drive bundle
// for the 7-segment scan controller.
interface m_7seg_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  w_we;
    logic [4*DIGITS-1:0]   w_data;
    logic                  w_lzb;
    logic [6:0]            w_seg;
    logic [3:0]            r_nibble;
    logic [6:0]            r_seg;
    logic [DIGITS-1:0]     r_an;
    logic                  r_ack;
    logic                  r_frame;

    modport master (
        output w_we, w_data, w_lzb, w_seg,
        input  r_nibble, r_seg, r_an, r_ack, r_frame
    );

    modport slave (
        input  w_we, w_data, w_lzb, w_seg,
        output r_nibble, r_seg, r_an, r_ack, r_frame
    );
endinterface

// File: rtl/m_7seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: gap/drive sequencing,
// leading-zero blanking and frame-boundary double buffering.
module m_7seg_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int HOLD_CYCLES = 1000,
    parameter int BLANK_GAP   = 2
) (
    input  logic               w_clk,
    input  logic               w_rst,
    m_7seg_scan_ctrl_if.slave  bus
);
    typedef enum logic {GAP, DRIVE} state_t;

    localparam int CMAX = (HOLD_CYCLES > BLANK_GAP) ?
                          HOLD_CYCLES : BLANK_GAP;
    localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int KW = $clog2(DIGITS);
    localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_GAP - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [KW-1:0] K_LAST    = KW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_ONE = DIGITS'(1);

    state_t              r_state;
    logic [KW-1:0]       r_k;
    logic [CW-1:0]       r_cnt;
    logic [4*DIGITS-1:0] r_active;
    logic [4*DIGITS-1:0] r_pending;
    logic                r_pend_vld;
    logic [3:0]          r_nibble;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_an;
    logic                r_ack;
    logic                r_frame;

    logic                w_gap_end;
    logic                w_drive_end;
    logic                w_commit;
    logic                w_blank;
    logic [KW-1:0]       w_k_next;
    logic [4*DIGITS-1:0] w_next_act;

    assign w_gap_end   = (r_state == GAP) && (r_cnt == GAP_LAST);
    assign w_drive_end = (r_state == DRIVE) && (r_cnt == HOLD_LAST);
    assign w_commit    = w_drive_end && (r_k == K_LAST) && r_pend_vld;
    assign w_k_next    = (r_k == K_LAST) ? '0 : r_k + 1'b1;
    assign w_next_act  = w_commit ? r_pending : r_active;

    // Blank digit k only if it and every more significant digit is zero.
    always_comb begin
        w_blank = bus.w_lzb && (r_k != '0);
        for (int j = 0; j < DIGITS; j++) begin
            if ((KW'(j) >= r_k) && (r_active[4*j +: 4] != 4'd0))
                w_blank = 1'b0;
        end
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state    <= GAP;
            r_k        <= '0;
            r_cnt      <= '0;
            r_active   <= '0;
            r_pending  <= '0;
            r_pend_vld <= 1'b0;
            r_nibble   <= 4'd0;
            r_seg      <= 7'd0;
            r_an       <= '0;
            r_ack      <= 1'b0;
            r_frame    <= 1'b0;
        end else begin
            r_ack <= w_commit;
            // A load on the commit edge lands in the next frame.
            if (bus.w_we) begin
                r_pending  <= bus.w_data;
                r_pend_vld <= 1'b1;
            end else if (w_commit) begin
                r_pend_vld <= 1'b0;
            end
            if (w_commit)
                r_active <= r_pending;
            unique case (r_state)
                GAP: begin
                    if (w_gap_end) begin
                        r_cnt   <= '0;
                        r_state <= DRIVE;
                        r_seg   <= w_blank ? 7'd0 : bus.w_seg;
                        r_an    <= AN_ONE << r_k;
                        r_frame <= (r_k == K_LAST) &&
                                   (HOLD_LAST == '0);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DRIVE: begin
                    if (w_drive_end) begin
                        r_cnt    <= '0;
                        r_state  <= GAP;
                        r_an     <= '0;
                        r_seg    <= 7'd0;
                        r_k      <= w_k_next;
                        r_nibble <= w_next_act[4*w_k_next +: 4];
                        r_frame  <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                        r_frame <= (r_k == K_LAST) &&
                                   ((r_cnt + CW'(1)) == HOLD_LAST);
                    end
                end
            endcase
        end
    end

    assign bus.r_nibble = r_nibble;
    assign bus.r_seg    = r_seg;
    assign bus.r_an     = r_an;
    assign bus.r_ack    = r_ack;
    assign bus.r_frame  = r_frame;
endmodule
